idv_osc_scan_ctrl: RTL

- Sequencer for a 63-entry IDV ring-oscillator bank with inputs `enosc[63:1]` and `sleep_b`, and a shared output `hfbankl`.
- Wakes the bank and enables one oscillator at a time over a programmed index range.
- For each oscillator, waits a settle time, then counts `hfbankl` rising edges over a fixed window.
- Returns one result per oscillator over a valid/ready port to the IDV debug/readout logic.

---
 rtl/idv_osc_scan_ctrl.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/idv_osc_scan_ctrl.sv
// Scan sequencer for the IDV ring-oscillator bank: wakes the bank, walks a one-hot
// enable over [osc_first, osc_last], and returns a rising-edge count per oscillator.
module idv_osc_scan_ctrl #(
    parameter int NUM_OSC  = 63,
    parameter int CNT_W    = 16,
    parameter int SETTLE_W = 8,
    parameter int WAKE_CYC = 4
) (
    input  logic                idvdebug_clki,
    input  logic                rst_b,
    input  logic                start,
    input  logic                abort,
    input  logic [5:0]          osc_first,
    input  logic [5:0]          osc_last,
    input  logic [SETTLE_W-1:0] settle_cycles,
    input  logic [CNT_W-1:0]    window_cycles,
    input  logic                hfbankl,
    output logic [NUM_OSC-1:0]  enosc,
    output logic                sleep_b,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [5:0]          res_idx,
    output logic [CNT_W-1:0]    res_count,
    output logic                res_sat,
    output logic                busy,
    output logic                done,
    output logic                cfg_err
);

    localparam int TMR_A  = (CNT_W > SETTLE_W) ? CNT_W : SETTLE_W;
    localparam int WAKE_W = $clog2(WAKE_CYC + 1);
    localparam int TMR_W  = (TMR_A > WAKE_W) ? TMR_A : WAKE_W;
    localparam logic [6:0]       NUM_OSC_L = 7'(NUM_OSC);
    localparam logic [CNT_W-1:0] CNT_ONES  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAKE,
        S_SETTLE,
        S_MEASURE,
        S_REPORT,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [1:0]           rst_sync_q;
    logic                 rst_n;
    logic                 hf_s1_q, hf_s2_q, hf_prev_q;
    logic                 hf_edge;
    logic [TMR_W-1:0]     tmr_q, tmr_d;
    logic [TMR_W-1:0]     settle_t, window_t;
    logic [5:0]           idx_q, idx_d;
    logic [5:0]           first_q, last_q;
    logic [SETTLE_W-1:0]  settle_q;
    logic [CNT_W-1:0]     window_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 sat_q, sat_d;
    logic [5:0]           res_idx_q, res_idx_d;
    logic [CNT_W-1:0]     res_count_q, res_count_d;
    logic                 res_sat_q, res_sat_d;
    logic                 cfg_err_q, cfg_err_d;
    logic                 cfg_load;
    logic                 cfg_bad;
    logic [NUM_OSC-1:0]   osc_oh;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge idvdebug_clki or negedge rst_b) begin
        if (!rst_b) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n = rst_sync_q[1];

    assign hf_edge  = hf_s2_q & ~hf_prev_q;
    assign cfg_bad  = (osc_first == 6'd0) || ({1'b0, osc_last} > NUM_OSC_L) ||
                      (osc_first > osc_last);
    assign settle_t = (settle_q == '0) ? TMR_W'(1) : TMR_W'(settle_q);
    assign window_t = (window_q == '0) ? TMR_W'(1) : TMR_W'(window_q);

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        res_idx_d   = res_idx_q;
        res_count_d = res_count_q;
        res_sat_d   = res_sat_q;
        cfg_err_d   = 1'b0;
        cfg_load    = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_bad) begin
                            cfg_err_d = 1'b1;
                        end else begin
                            cfg_load = 1'b1;
                            tmr_d    = TMR_W'(WAKE_CYC);
                            state_d  = S_WAKE;
                        end
                    end
                end
                S_WAKE: begin
                    if (tmr_q <= TMR_W'(1)) begin
                        idx_d   = first_q;
                        tmr_d   = settle_t;
                        state_d = S_SETTLE;
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (tmr_q <= TMR_W'(1)) begin
                        tmr_d   = window_t;
                        cnt_d   = '0;
                        sat_d   = 1'b0;
                        state_d = S_MEASURE;
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
                S_MEASURE: begin
                    // Counter pins at all-ones; reaching it marks the result saturated.
                    if (hf_edge && (cnt_q != CNT_ONES)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (cnt_d == CNT_ONES) begin
                        sat_d = 1'b1;
                    end
                    if (tmr_q <= TMR_W'(1)) begin
                        res_idx_d   = idx_q;
                        res_count_d = cnt_d;
                        res_sat_d   = sat_d;
                        state_d     = S_REPORT;
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end
                S_REPORT: begin
                    if (res_ready) begin
                        if (idx_q == last_q) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + 6'd1;
                            tmr_d   = settle_t;
                            state_d = S_SETTLE;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge idvdebug_clki or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            hf_s1_q     <= 1'b0;
            hf_s2_q     <= 1'b0;
            hf_prev_q   <= 1'b0;
            tmr_q       <= '0;
            idx_q       <= '0;
            first_q     <= '0;
            last_q      <= '0;
            settle_q    <= '0;
            window_q    <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            res_idx_q   <= '0;
            res_count_q <= '0;
            res_sat_q   <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hf_s1_q     <= hfbankl;
            hf_s2_q     <= hf_s1_q;
            hf_prev_q   <= hf_s2_q;
            tmr_q       <= tmr_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            res_idx_q   <= res_idx_d;
            res_count_q <= res_count_d;
            res_sat_q   <= res_sat_d;
            cfg_err_q   <= cfg_err_d;
            if (cfg_load) begin
                first_q  <= osc_first;
                last_q   <= osc_last;
                settle_q <= settle_cycles;
                window_q <= window_cycles;
            end
        end
    end

    // Outputs decode from the state register so reset drops them without a clock.
    assign osc_oh    = NUM_OSC'(1) << (idx_q - 6'd1);
    assign enosc     = ((state_q == S_SETTLE) || (state_q == S_MEASURE) ||
                        (state_q == S_REPORT)) ? osc_oh : '0;
    assign sleep_b   = (state_q == S_WAKE) || (state_q == S_SETTLE) ||
                       (state_q == S_MEASURE) || (state_q == S_REPORT);
    assign res_valid = (state_q == S_REPORT);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign cfg_err   = cfg_err_q;
    assign res_idx   = res_idx_q;
    assign res_count = res_count_q;
    assign res_sat   = res_sat_q;

endmodule
